// File: rtl/ifm_arb_pkg.sv
// Shared defaults and state encoding for the IFM read-port arbiter.
package ifm_arb_pkg;

  localparam int unsigned NR_DEF = 4;
  localparam int unsigned AW_DEF = 11;
  localparam int unsigned DW_DEF = 64;
  localparam int unsigned QD_DEF = 4;
  localparam int unsigned IDW    = $clog2(NR_DEF);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ifm_ord_fifo.sv
// Order FIFO of granted channel ids; head names the owner of the next returning read burst.
module ifm_ord_fifo
  import ifm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = QD_DEF,
  parameter int unsigned W     = IDW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  // A push while full is legal only alongside a pop: the freed slot is the one being written.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/ifm_rd_arb.sv
// Round-robin per-burst arbiter for the IFM-buffer read port with in-order data return routing.
module ifm_rd_arb
  import ifm_arb_pkg::*;
#(
  parameter int unsigned NR = NR_DEF,
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned QD = QD_DEF,
  localparam int unsigned IW = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] m_addr,
  input  logic [NR-1:0]    m_addr_first,
  input  logic [NR-1:0]    m_addr_last,
  input  logic [NR-1:0]    m_addr_valid,
  output logic [NR-1:0]    m_addr_ready,
  output logic [AW-1:0]    s_addr,
  output logic             s_addr_first,
  output logic             s_addr_last,
  output logic             s_addr_valid,
  input  logic             s_addr_ready,
  input  logic [DW-1:0]    m_data,
  input  logic             m_data_first,
  input  logic             m_data_last,
  input  logic             m_data_valid,
  output logic             m_data_ready,
  output logic [DW-1:0]    s_data,
  output logic             s_data_first,
  output logic             s_data_last,
  output logic [NR-1:0]    s_data_valid,
  input  logic [NR-1:0]    s_data_ready,
  output logic [IW-1:0]    gnt_id,
  output logic             busy
);

  localparam int unsigned CW = $clog2(QD) + 1;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] win_id, cand;
  logic          win_found;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IW-1:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic          addr_hs;

  assign gnt_id = gnt_q;
  assign busy   = (state_q == BURST) || (fifo_count != '0);

  // First valid channel scanning upward from the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_q;
    cand      = rr_q;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = IW'((32'(rr_q) + k) % NR);
      if (!win_found && m_addr_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    fifo_push    = 1'b0;
    addr_hs      = 1'b0;
    s_addr       = '0;
    s_addr_first = 1'b0;
    s_addr_last  = 1'b0;
    s_addr_valid = 1'b0;
    m_addr_ready = '0;
    case (state_q)
      IDLE: begin
        if (win_found && !fifo_full) begin
          gnt_d     = win_id;
          fifo_push = 1'b1;
          state_d   = BURST;
        end
      end
      BURST: begin
        s_addr              = m_addr[gnt_q*AW +: AW];
        s_addr_first        = m_addr_first[gnt_q];
        s_addr_last         = m_addr_last[gnt_q];
        s_addr_valid        = m_addr_valid[gnt_q];
        m_addr_ready[gnt_q] = s_addr_ready;
        addr_hs             = m_addr_valid[gnt_q] && s_addr_ready;
        if (addr_hs && m_addr_last[gnt_q]) begin
          rr_d    = (gnt_q == IW'(NR - 1)) ? '0 : gnt_q + IW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return data goes to the FIFO head; nothing is accepted while no burst is outstanding.
  always_comb begin
    s_data       = '0;
    s_data_first = 1'b0;
    s_data_last  = 1'b0;
    s_data_valid = '0;
    m_data_ready = 1'b0;
    fifo_pop     = 1'b0;
    if (!fifo_empty) begin
      s_data                  = m_data;
      s_data_first            = m_data_first;
      s_data_last             = m_data_last;
      s_data_valid[fifo_head] = m_data_valid;
      m_data_ready            = s_data_ready[fifo_head];
      fifo_pop                = m_data_valid && s_data_ready[fifo_head] && m_data_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
    end
  end

  ifm_ord_fifo #(
    .DEPTH (QD),
    .W     (IW)
  ) u_ord_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (gnt_d),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
